// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master controller and the register-file slave
// it talks to: FSM state encoding, address-byte field layout, burst limit, and
// small helpers for building the address byte and the per-command byte count.
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCLK_HI,
    ST_SCLK_LO,
    ST_GAP,
    ST_HOLD
  } spi_state_e;

  localparam logic RW_WRITE  = 1'b1;
  localparam int   RW_BIT    = 7;
  localparam int   ADDR_W    = 7;
  localparam int   MAX_BURST = 4;

  // Address byte as the slave expects it: direction in bit 7, register index below.
  function automatic logic [7:0] make_addr_byte(input logic rw, input logic [ADDR_W-1:0] addr);
    logic [7:0] b;
    b              = '0;
    b[RW_BIT]      = rw;
    b[ADDR_W-1:0]  = addr;
    return b;
  endfunction

  // Bytes on the wire: address plus burst for writes, address plus dummy for reads.
  function automatic logic [2:0] byte_total(input logic rw, input int burst);
    return (rw == RW_WRITE) ? 3'(burst + 1) : 3'd2;
  endfunction

endpackage

// File: rtl/spi_sclk_tick.sv
// -----------------------------------------------------------------------------
// spi_sclk_tick
// Phase timer for the SPI master. Every FSM phase lasts CLK_DIV clk cycles;
// restart reloads the counter on the edge that enters a new phase and
// phase_end is high during the last cycle of that phase.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   restart    pulse on the edge where the FSM changes state
//   phase_end  high in the final cycle of the current phase
// -----------------------------------------------------------------------------
module spi_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase_end
);

  logic [7:0] cnt;

  // Down-counter: loaded with CLK_DIV-1 on a state change and parked at zero,
  // so a phase spans exactly CLK_DIV cycles including the entry cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 8'd0;
    end else if (restart) begin
      cnt <= 8'(CLK_DIV - 1);
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign phase_end = (cnt == 8'd0);

endmodule

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// SPI mode-0 master for the on-board register-file slave. A write sends the
// address byte (bit 7 set) followed by BURST_LEN data bytes; a read sends the
// address byte (bit 7 clear) followed by a 0x00 dummy byte while the reply is
// shifted in from MISO.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   start      command strobe, only looked at in IDLE
//   rw         1 = write, 0 = read
//   addr       7-bit register address
//   wdata      write bytes, byte 0 in [7:0] goes out first
//   busy       high while a command is in progress
//   done       one-cycle pulse as CS returns high
//   byte_done  one-cycle pulse after each completed byte
//   rdata      last read result, held until overwritten by another read
//   SCLK       serial clock, idle low
//   CS         chip select, active low
//   MOSI       serial data out, MSB first
//   MISO       serial data in, MSB first
// -----------------------------------------------------------------------------
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rw,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [8*MAX_BURST-1:0] wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   byte_done,
  output logic [7:0]             rdata,
  output logic                   SCLK,
  output logic                   CS,
  output logic                   MOSI,
  input  logic                   MISO
);

  spi_state_e             state;
  logic                   rw_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [8*MAX_BURST-1:0] wdata_q;
  logic [7:0]             tx_sh;
  logic [7:0]             rx_sh;
  logic [3:0]             bit_cnt;
  logic [2:0]             byte_cnt;
  logic [2:0]             n_total;
  logic [2:0]             next_idx;
  logic [7:0]             next_byte;
  logic                   restart;
  logic                   phase_end;

  // In IDLE the timer is restarted by an accepted start; elsewhere every
  // phase_end is a state change, so it doubles as the restart.
  assign restart  = (state == ST_IDLE) ? start : phase_end;
  assign n_total  = byte_total(rw_q, BURST_LEN);
  assign next_idx = byte_cnt + 3'd1;

  spi_sclk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .phase_end (phase_end)
  );

  // Byte that follows the current one; zero once the command is exhausted so
  // MOSI settles low during HOLD. Reads only ever follow with the dummy 0x00.
  always_comb begin
    next_byte = 8'h00;
    if (rw_q == RW_WRITE && next_idx < n_total) begin
      case (next_idx)
        3'd1:    next_byte = wdata_q[7:0];
        3'd2:    next_byte = wdata_q[15:8];
        3'd3:    next_byte = wdata_q[23:16];
        3'd4:    next_byte = wdata_q[31:24];
        default: next_byte = 8'h00;
      endcase
    end
  end

  // Main sequencer. All pins are registered. MISO is sampled on the edge that
  // raises SCLK; MOSI moves on the edge that drops SCLK, and on the eighth
  // falling edge it jumps straight to bit 7 of the next byte so the GAP phase
  // already presents it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_sh     <= 8'h00;
      rx_sh     <= 8'h00;
      bit_cnt   <= 4'd0;
      byte_cnt  <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      byte_done <= 1'b0;
      rdata     <= 8'h00;
      SCLK      <= 1'b0;
      CS        <= 1'b1;
      MOSI      <= 1'b0;
    end else begin
      done      <= 1'b0;
      byte_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            rw_q     <= rw;
            addr_q   <= addr;
            wdata_q  <= wdata;
            tx_sh    <= make_addr_byte(rw, addr);
            MOSI     <= rw;
            CS       <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= 4'd0;
            byte_cnt <= 3'd0;
            state    <= ST_SETUP;
          end
        end

        ST_SETUP, ST_GAP: begin
          if (phase_end) begin
            SCLK  <= 1'b1;
            rx_sh <= {rx_sh[6:0], MISO};
            state <= ST_SCLK_HI;
          end
        end

        ST_SCLK_HI: begin
          if (phase_end) begin
            SCLK    <= 1'b0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              tx_sh <= next_byte;
              MOSI  <= next_byte[7];
            end else begin
              tx_sh <= {tx_sh[6:0], 1'b0};
              MOSI  <= tx_sh[6];
            end
            state <= ST_SCLK_LO;
          end
        end

        ST_SCLK_LO: begin
          if (phase_end) begin
            if (bit_cnt < 4'd8) begin
              SCLK  <= 1'b1;
              rx_sh <= {rx_sh[6:0], MISO};
              state <= ST_SCLK_HI;
            end else begin
              byte_done <= 1'b1;
              bit_cnt   <= 4'd0;
              byte_cnt  <= next_idx;
              state     <= (next_idx < n_total) ? ST_GAP : ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (phase_end) begin
            CS    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            MOSI  <= 1'b0;
            if (rw_q != RW_WRITE) begin
              rdata <= rx_sh;
            end
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
// Two masters: dut_a with the default timing (CLK_DIV=4, BURST_LEN=4) and
// dut_b with CLK_DIV=2, BURST_LEN=1. Only one is active at a time and sel
// routes its pins to a shared monitor and slave model. Expected bytes and
// per-transaction results are queued when a command is issued and consumed
// as the bus activity appears.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;

  typedef struct {
    int         len;
    int         nbytes;
    logic [7:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic        rw;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic        miso;

  logic        busy_a, done_a, bd_a, sclk_a, cs_a, mosi_a;
  logic        busy_b, done_b, bd_b, sclk_b, cs_b, mosi_b;
  logic [7:0]  rdata_a, rdata_b;

  logic        sel;
  logic        busy_m, done_m, bd_m, sclk_m, cs_m, mosi_m;
  logic [7:0]  rdata_m;

  int          total_cnt = 0;
  int          bad_cnt   = 0;

  logic [7:0]  byte_q[$];
  txn_t        txn_q[$];
  logic [7:0]  exp_rd [2];
  logic [7:0]  slave_byte;

  always #5 clk = ~clk;

  spi_master_ctrl #(.CLK_DIV(4), .BURST_LEN(4)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy_a), .done(done_a), .byte_done(bd_a), .rdata(rdata_a),
    .SCLK(sclk_a), .CS(cs_a), .MOSI(mosi_a), .MISO(miso)
  );

  spi_master_ctrl #(.CLK_DIV(2), .BURST_LEN(1)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy_b), .done(done_b), .byte_done(bd_b), .rdata(rdata_b),
    .SCLK(sclk_b), .CS(cs_b), .MOSI(mosi_b), .MISO(miso)
  );

  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign bd_m    = sel ? bd_b    : bd_a;
  assign sclk_m  = sel ? sclk_b  : sclk_a;
  assign cs_m    = sel ? cs_b    : cs_a;
  assign mosi_m  = sel ? mosi_b  : mosi_a;
  assign rdata_m = sel ? rdata_b : rdata_a;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected bus content for one command, from the protocol description.
  function automatic void push_expect(input logic s, input logic w, input logic [6:0] a,
                                      input logic [31:0] d);
    int   n;
    int   div;
    txn_t t;
    n   = w ? (1 + (s ? 1 : 4)) : 2;
    div = s ? 2 : 4;
    byte_q.push_back({w, a});
    if (w) begin
      for (int k = 0; k < n - 1; k++) byte_q.push_back(d[8*k +: 8]);
    end else begin
      byte_q.push_back(8'h00);
      exp_rd[s] = slave_byte;
    end
    t.len    = div * (2 + 16 * n + (n - 1));
    t.nbytes = n;
    t.rdata  = exp_rd[s];
    txn_q.push_back(t);
  endfunction

  task automatic apply_stimulus(input logic s, input logic w, input logic [6:0] a,
                                input logic [31:0] d, input logic hold);
    rw    = w;
    addr  = a;
    wdata = d;
    push_expect(s, w, a, d);
    if (s) start_b = 1'b1;
    else   start_a = 1'b1;
    if (!hold) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
    end
  endtask

  // Monitor and slave model state
  logic       prev_sclk, prev_cs;
  int         cs_low_cnt, cs_hi_cnt, hi_run, lo_run, bit_idx, bd_cnt;
  int         txn_end_cnt = 0;
  logic [7:0] sh_byte;
  logic [15:0] miso_sh;
  txn_t       cur_t;
  logic [7:0] exp_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sclk  = 1'b0;
      prev_cs    = 1'b1;
      cs_low_cnt = 0;
      cs_hi_cnt  = 0;
      hi_run     = 0;
      lo_run     = 0;
      bit_idx    = 0;
      bd_cnt     = 0;
      sh_byte    = 8'h00;
      miso_sh    = 16'h0000;
      miso       = 1'b0;
    end else begin
      if (prev_cs && !cs_m) begin
        check_output("cs_high_gap", cs_hi_cnt >= 1, 1);
        cs_low_cnt = 0;
        bd_cnt     = 0;
        bit_idx    = 0;
        miso_sh    = {8'hC3, slave_byte};
        miso       = miso_sh[15];
      end
      if (sclk_m && !prev_sclk) begin
        if (bit_idx != 0) check_output("sclk_low_len", lo_run, sel ? 2 : 4);
        hi_run  = 0;
        sh_byte = {sh_byte[6:0], mosi_m};
        bit_idx++;
        if (bit_idx == 8) begin
          bit_idx = 0;
          if (byte_q.size() == 0) begin
            check_output("byte_q_empty", 0, 1);
          end else begin
            exp_byte = byte_q.pop_front();
            check_output("mosi_byte", sh_byte, exp_byte);
          end
        end
      end
      if (!sclk_m && prev_sclk) begin
        check_output("sclk_high_len", hi_run, sel ? 2 : 4);
        lo_run  = 0;
        miso_sh = {miso_sh[14:0], 1'b0};
        miso    = miso_sh[15];
      end
      if (sclk_m) hi_run++;
      else        lo_run++;
      if (bd_m) bd_cnt++;
      if (cs_m && !prev_cs) begin
        if (txn_q.size() == 0) begin
          check_output("txn_q_empty", 0, 1);
        end else begin
          cur_t = txn_q.pop_front();
          check_output("cs_low_len", cs_low_cnt, cur_t.len);
          check_output("byte_done_cnt", bd_cnt, cur_t.nbytes);
          check_output("done_at_end", done_m, 1);
          check_output("busy_at_end", busy_m, 0);
          check_output("rdata", rdata_m, cur_t.rdata);
        end
        txn_end_cnt++;
        cs_hi_cnt = 0;
      end else if (done_m) begin
        check_output("done_stray", done_m, 0);
      end
      if (cs_m) cs_hi_cnt++;
      else      cs_low_cnt++;
      prev_sclk = sclk_m;
      prev_cs   = cs_m;
    end
  end

  task automatic wait_txn(input int target);
    for (int i = 0; i < 3000 && txn_end_cnt < target; i++) @(negedge clk);
    check_output("txn_timeout", txn_end_cnt >= target, 1);
  endtask

  int base;

  initial begin
    rst_n      = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    rw         = 1'b0;
    addr       = '0;
    wdata      = '0;
    sel        = 1'b0;
    slave_byte = 8'h00;
    exp_rd[0]  = 8'h00;
    exp_rd[1]  = 8'h00;
    repeat (3) @(negedge clk);
    check_output("rst_cs_a",    cs_a,    1);
    check_output("rst_sclk_a",  sclk_a,  0);
    check_output("rst_mosi_a",  mosi_a,  0);
    check_output("rst_busy_a",  busy_a,  0);
    check_output("rst_done_a",  done_a,  0);
    check_output("rst_bd_a",    bd_a,    0);
    check_output("rst_rdata_a", rdata_a, 0);
    check_output("rst_cs_b",    cs_b,    1);
    check_output("rst_busy_b",  busy_b,  0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] write burst addr 02");
    base = txn_end_cnt;
    apply_stimulus(1'b0, 1'b1, 7'h02, 32'hDDCCBBAA, 1'b0);
    wait_txn(base + 1);
    @(negedge clk);
    check_output("busy_after_write", busy_a, 0);
    check_output("cs_after_write", cs_a, 1);

    $display("[TB] read addr 01");
    slave_byte = 8'h5A;
    apply_stimulus(1'b0, 1'b0, 7'h01, 32'h0, 1'b0);
    wait_txn(base + 2);
    check_output("rdata_read1", rdata_a, 8'h5A);

    $display("[TB] start held across a transaction");
    apply_stimulus(1'b0, 1'b1, 7'h10, 32'h44332211, 1'b1);
    repeat (60) @(negedge clk);
    apply_stimulus(1'b0, 1'b1, 7'h33, 32'h88776655, 1'b1);
    wait_txn(base + 3);
    @(negedge clk);
    start_a = 1'b0;
    wait_txn(base + 4);

    $display("[TB] back-to-back read then write");
    slave_byte = 8'hA5;
    apply_stimulus(1'b0, 1'b0, 7'h07, 32'h0, 1'b0);
    for (int i = 0; i < 500 && !done_a; i++) @(negedge clk);
    check_output("b2b_done_seen", done_a, 1);
    apply_stimulus(1'b0, 1'b1, 7'h2A, 32'hCAFEF00D, 1'b0);
    wait_txn(base + 6);
    check_output("rdata_held", rdata_a, 8'hA5);

    $display("[TB] reset during third byte");
    apply_stimulus(1'b0, 1'b1, 7'h15, 32'h0BADF00D, 1'b0);
    for (int i = 0; i < 500 && bd_cnt < 2; i++) @(negedge clk);
    check_output("reach_byte3", bd_cnt >= 2, 1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_cs",   cs_a,   1);
    check_output("async_sclk", sclk_a, 0);
    check_output("async_busy", busy_a, 0);
    byte_q.delete();
    txn_q.delete();
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("no_done_in_reset", done_a, 0);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("no_done_after_reset", done_a, 0);
    end
    base = txn_end_cnt;
    apply_stimulus(1'b0, 1'b1, 7'h55, 32'h76543210, 1'b0);
    wait_txn(base + 1);

    $display("[TB] CLK_DIV=2 BURST_LEN=1 write");
    sel = 1'b1;
    @(negedge clk);
    apply_stimulus(1'b1, 1'b1, 7'h00, 32'h0000003C, 1'b0);
    wait_txn(base + 2);

    repeat (4) @(negedge clk);
    check_output("scoreboard_left", byte_q.size() + txn_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
